// File: rtl/capsense_scan_ctrl.sv
// Scan scheduler and debounce filter for the CapSense core.
// Define CAPSENSE_SCAN_IRQ_EN to enable the button-change interrupt on irq_o.
module capsense_scan_ctrl #(
    parameter int FREQUENCY = 24,
    parameter int N         = 4,
    parameter int POLL_BITS = 17,
    parameter int SETTLE    = 255,
    parameter int DEB       = 3
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         enable_i,
    input  logic         scan_now_i,
    input  logic [N-1:0] cs_sampled_i,
    output logic         cs_ena_o,
    output logic         cs_start_o,
    output logic [N-1:0] buttons_o,
    output logic         valid_o,
    output logic         busy_o,
    output logic         irq_o,
    input  logic         ack_i
);

    // Nearest integer to FREQUENCY/1.5, i.e. a ~1.5 MHz sample tick.
    localparam int MOD_SAMP = (FREQUENCY * 2 + 1) / 3;
    localparam int PRESC_W  = (MOD_SAMP > 1) ? $clog2(MOD_SAMP) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST  = PRESC_W'(MOD_SAMP - 1);
    localparam logic [15:0]        SETTLE_LAST = 16'(SETTLE - 1);
    localparam logic [3:0]         DC_LAST     = 4'(DEB - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_SETTLE,
        S_CAPTURE
    } state_t;

    state_t                 state_q, state_d;
    logic [PRESC_W-1:0]     presc_q;
    logic [POLL_BITS-1:0]   poll_q;
    logic [15:0]            settle_q;
    logic                   pending_q;
    logic                   pend_clr, settle_clr, settle_inc;
    logic                   poll_wrap;
    logic [N-1:0]           btn_d;
    logic [N-1:0][3:0]      dc_q, dc_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q  <= '0;
            cs_ena_o <= 1'b0;
        end else begin
            cs_ena_o <= (presc_q == PRESC_LAST);
            presc_q  <= (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
        end
    end

    assign poll_wrap = cs_ena_o && enable_i && (&poll_q);

    // A new request wins over the IDLE-exit clear so that no request is lost.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            poll_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            if (cs_ena_o && enable_i) begin
                poll_q <= poll_q + 1'b1;
            end
            pending_q <= (pending_q && !pend_clr) || scan_now_i || poll_wrap;
        end
    end

    always_comb begin
        state_d    = state_q;
        pend_clr   = 1'b0;
        settle_clr = 1'b0;
        settle_inc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pending_q) begin
                    pend_clr = 1'b1;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (cs_ena_o) begin
                    settle_clr = 1'b1;
                    state_d    = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cs_ena_o) begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d = S_CAPTURE;
                    end else begin
                        settle_inc = 1'b1;
                    end
                end
            end
            S_CAPTURE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            settle_q   <= '0;
            cs_start_o <= 1'b0;
            valid_o    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cs_start_o <= (state_d == S_START);
            valid_o    <= (state_q == S_CAPTURE);
            if (settle_clr) begin
                settle_q <= '0;
            end else if (settle_inc) begin
                settle_q <= settle_q + 16'd1;
            end
        end
    end

    assign busy_o = (state_q != S_IDLE);

    always_comb begin
        btn_d = buttons_o;
        dc_d  = dc_q;
        for (int i = 0; i < N; i++) begin
            if (cs_sampled_i[i] == buttons_o[i]) begin
                dc_d[i] = 4'd0;
            end else if (dc_q[i] == DC_LAST) begin
                btn_d[i] = ~buttons_o[i];
                dc_d[i]  = 4'd0;
            end else begin
                dc_d[i] = dc_q[i] + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buttons_o <= '0;
            dc_q      <= '0;
        end else if (state_q == S_CAPTURE) begin
            buttons_o <= btn_d;
            dc_q      <= dc_d;
        end
    end

`ifdef CAPSENSE_SCAN_IRQ_EN
    logic btn_change;
    assign btn_change = (state_q == S_CAPTURE) && (btn_d != buttons_o);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_o <= 1'b0;
        end else if (btn_change) begin
            irq_o <= 1'b1;
        end else if (ack_i) begin
            irq_o <= 1'b0;
        end
    end
`else
    logic unused_ack;
    assign unused_ack = ack_i;
    assign irq_o      = 1'b0;
`endif

endmodule

// File: doc/capsense_scan_ctrl.md
# capsense_scan_ctrl

Scan scheduler and result filter for the CapSense core. Generates the core's sample enable (`ena_i`) and scan start (`start_i`) strobes and sequences each scan through settle and capture. Debounces the sampled button vector across consecutive scans and publishes a stable vector with a completion pulse and an optional change interrupt. Replaces the fixed free-running dividers in the system wrapper with a controllable scan FSM.

## Interface
- `FREQUENCY`, 24: system clock in MHz. Prescaler modulus `MOD_SAMP` = integer(FREQUENCY/1.5), giving about a 1.5 MHz sample tick.
- `N`, 4: number of buttons.
- `POLL_BITS`, 17: width of the poll-interval counter, counted in sample ticks.
- `SETTLE`, 255: sample ticks between the end of the start strobe and capture. Range 1..65535.
- `DEB`, 3: consecutive agreeing scans needed to change a button. Range 1..15.
- `clk_i`, in, 1: system clock. One clock domain.
- `rst_ni`, in, 1: asynchronous, active-low reset.
- `enable_i`, in, 1: enables periodic scanning.
- `scan_now_i`, in, 1: one-cycle request for an immediate scan. Honored even when `enable_i` = 0.
- `cs_sampled_i`, in, N: raw sampled vector from the CapSense core.
- `cs_ena_o`, out, 1: sample-tick strobe to the core.
- `cs_start_o`, out, 1: scan start to the core.
- `buttons_o`, out, N: debounced button state.
- `valid_o`, out, 1: one-cycle pulse when a scan completes.
- `busy_o`, out, 1: high while a scan is in progress.
- `irq_o`, out, 1: change interrupt, level.
- `ack_i`, in, 1: clears `irq_o`.

## Operation
- **Prescaler**
  - Free-running counter 0..MOD_SAMP-1.
  - `cs_ena_o` is registered and high for one cycle each time the counter equals MOD_SAMP-1.
  - Runs regardless of FSM state.
- **Poll counter**
  - POLL_BITS wide; increments on each tick while `enable_i` = 1. Holds its value when `enable_i` = 0.
  - A wrap from all-ones to 0 sets `pending`. `scan_now_i` also sets `pending`.
  - Requests arriving while `pending` is already set, or while a scan is in progress, merge into a single `pending`.
- **FSM** (state, then action and transition):
  - IDLE: if `pending`, clear `pending` and go to START.
  - START: `cs_start_o` = 1. On a cycle where `cs_ena_o` = 1, clear the settle counter and go to SETTLE.
  - SETTLE: count ticks. When the count reaches SETTLE, go to CAPTURE.
  - CAPTURE: one cycle. Run the debounce update, pulse `valid_o`, return to IDLE.
- **Outputs**
  - `busy_o` = (state != IDLE).
  - `cs_start_o` is a registered decode of START.
- **Debounce** (per bit i, counter `dc[i]` 4 bits wide, evaluated only in CAPTURE):
  - If `cs_sampled_i[i]` == `buttons_o[i]`: clear `dc[i]`.
  - Else, if `dc[i]` == DEB-1: toggle `buttons_o[i]` and clear `dc[i]`.
  - Otherwise: increment `dc[i]`.
  - With DEB = 1 a difference updates immediately.
- **Boundary cases**
  - `enable_i` falling mid-scan: the scan completes normally.
  - Reset asserted at any time: immediate return to IDLE with all state cleared.

## Timing
- **Reset values:** all outputs 0; all counters 0; `pending` = 0; all `dc` = 0.
- **Sample tick:** the first `cs_ena_o` occurs MOD_SAMP cycles after reset release, then every MOD_SAMP cycles.
- **Scan request to start:** for `scan_now_i` sampled at clock edge k, `pending` is set at edge k. START is entered at edge k+1, so `cs_start_o` is high from k+1.
- **Start strobe width:** `cs_start_o` stays high through the first tick cycle inside START and falls on the following edge. Width is 1..MOD_SAMP cycles.
- **Scan length:** CAPTURE occurs on the cycle after the SETTLE-th tick counted in SETTLE.
- **Completion:** `buttons_o`, `valid_o` and `irq_o` update at the edge that ends CAPTURE.
- **Back-to-back scans:** a `pending` set during a scan starts the next scan 1 cycle after returning to IDLE.

## Configuration
- **`CAPSENSE_SCAN_IRQ_EN` defined:**
  - `irq_o` sets when any `buttons_o` bit changes in CAPTURE.
  - `irq_o` clears on `ack_i` = 1.
  - If a set and `ack_i` occur in the same cycle, the set wins.
- **Undefined:**
  - `irq_o` is tied to 0 and `ack_i` is ignored.
  - Ports remain present, so the interface is identical in both builds.

## Test plan
Common parameters: FREQUENCY=24, N=4, POLL_BITS=4, SETTLE=4, DEB=2.
- **Reset and prescaler:** release reset -> all outputs 0; `cs_ena_o` pulses at cycles 16, 32, 48 after release.
- **Manual scan:** `enable_i` = 0, pulse `scan_now_i` -> `cs_start_o` high 2 edges later and falls after the next tick; `valid_o` pulses once after 4 settle ticks; `busy_o` is high throughout the scan.
- **Debounce:** `cs_sampled_i` = 4'b0101 over successive scans -> `buttons_o` = 0 after scan 1 and 4'b0101 after scan 2. A glitch to 4'b0100 for one scan -> no change to `buttons_o`.
- **Periodic polling:** `enable_i` = 1 -> a scan starts every 16 ticks (poll wrap). `scan_now_i` pulsed during a scan -> exactly one extra scan follows.
- **IRQ (with macro):** a button change sets `irq_o`. `ack_i` in the same cycle as a new change -> `irq_o` stays 1. `ack_i` alone -> `irq_o` = 0. Without the macro, `irq_o` stays 0 throughout.
- **Reset mid-scan:** assert `rst_ni` low during SETTLE -> `busy_o`, `cs_start_o`, `buttons_o` = 0 immediately; after release there is no scan until a new request.
